motor_exec: RTL
===============

MOTOR_EXEC -- requirements
Module: motor_exec

Interface
REQ-001 SHALL have parameter STEP_DIV, default 1000: sysclk cycles per step period; legal range 2..65535.
REQ-002 SHALL have parameter PULSE_W, default 10: cycles Step is held high per step; legal range 1..STEP_DIV-1.
REQ-003 SHALL have port sysclk, input, 1 bit: clock, all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port Value, input, 12 bits: target position as BCD, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 SHALL have port Motor, input, 6 bits: one-hot motor select, bit0 = motor 1 … bit5 = motor 6.
REQ-007 SHALL have port Start, input, 1 bit: command strobe, sampled every cycle.
REQ-008 SHALL have port Step, output, 6 bits: per-motor step pulse.
REQ-009 SHALL have port Dir, output, 6 bits: per-motor direction, 1 = increasing position.
REQ-010 SHALL have port Busy, output, 1 bit: a command is executing.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port Err, output, 1 bit: one-cycle reject pulse.
REQ-013 SHALL have port CurPos, output, 10 bits: binary position of the last accepted motor.

Function
REQ-014 SHALL keep six 10-bit binary position registers Pos[1..6], range 0..999.
REQ-015 SHALL implement states IDLE, DECODE, MOVE and DONE.
REQ-016 In IDLE with Start=1, SHALL latch Value and Motor and validate them: Motor exactly one-hot, each BCD digit ≤9.
REQ-017 On an invalid command, SHALL pulse Err for the next cycle, leave Busy low, remain in IDLE, and leave Pos, Dir and CurPos unchanged.
REQ-018 On a valid command, SHALL enter DECODE on the next cycle with Busy=1, and SHALL set CurPos to the selected motor's Pos.
REQ-019 In DECODE, SHALL compute target = hundreds×100 + tens×10 + units as a 10-bit value.
REQ-020 In DECODE, if target equals Pos of the selected motor, SHALL go to DONE; otherwise SHALL set Dir of that motor (1 if target > Pos, else 0) and go to MOVE with the divider cleared to 0.
REQ-021 In MOVE, a 16-bit divider SHALL count 0..STEP_DIV-1 and wrap.
REQ-022 In MOVE, Step of the selected motor SHALL be 1 while divider < PULSE_W.
REQ-023 In MOVE, Step of all other motors SHALL be 0.
REQ-024 In MOVE, at divider = STEP_DIV-1, Pos of the selected motor SHALL change by ±1 per Dir, and CurPos SHALL track it.
REQ-025 In MOVE, if the updated Pos equals target, SHALL go to DONE.
REQ-026 In DONE, SHALL pulse Done=1 for exactly one cycle with Busy=0, then return to IDLE.
REQ-027 Busy SHALL be 1 only in DECODE and MOVE.
REQ-028 Start SHALL be ignored outside IDLE; there is no queueing.
REQ-029 Dir bits SHALL hold their last value between commands.
REQ-030 A move of N steps SHALL take N×STEP_DIV cycles in MOVE; total latency from the Start edge to the Done pulse is N×STEP_DIV+2 cycles, or 2 cycles when N=0.
REQ-031 Pos SHALL never leave 0..999, which is guaranteed because target is at most 999.

Reset
REQ-032 While rst=0, SHALL force state IDLE and Pos[1..6]=0, with Step=0, Dir=0, Busy=0, Done=0, Err=0, CurPos=0 and divider=0.
REQ-033 Reset asserted mid-move SHALL abort the move immediately with no further Step pulse, and position is lost (cleared to 0).

Verification (bench uses STEP_DIV=4, PULSE_W=2)
REQ-034 Bench SHALL check: after reset, Motor=6'b000001, Value=12'h003, Start pulse -> Dir[0]=1; 3 pulses on Step[0], each 2 high and 2 low cycles; Done 14 cycles after Start; CurPos=3.
REQ-035 Bench SHALL check: then Value=12'h001 on the same motor -> Dir[0]=0, 2 pulses, CurPos=1, Step[5:1] stay 0.
REQ-036 Bench SHALL check: Motor=6'b000011 or Value=12'h0A0 -> Err pulse the next cycle, Busy never rises, no Step activity.
REQ-037 Bench SHALL check: Value=12'h001 while motor 1 is at 1 -> Done 2 cycles after Start, no Step, Dir[0] unchanged.
REQ-038 Bench SHALL check: a Start pulse during MOVE is ignored (pulse count unchanged); rst low mid-move -> all outputs 0, a following move to 12'h002 produces 2 pulses.
REQ-039 Bench SHALL check: Motor=6'b100000, Value=12'h999 -> 999 pulses on Step[5], CurPos=999; then 12'h000 -> 999 pulses with Dir[5]=0.

Source files
------------

// File: rtl/motor_exec.sv
// Six-axis stepper command executor: validates a BCD target for one motor,
// then emits STEP_DIV-period step pulses until that motor's position reaches it.
module motor_exec #(
  parameter int STEP_DIV = 1000,
  parameter int PULSE_W  = 10
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [11:0] Value,
  input  logic [5:0]  Motor,
  input  logic        Start,
  output logic [5:0]  Step,
  output logic [5:0]  Dir,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [9:0]  CurPos
);

  typedef enum logic [1:0] {IDLE, DECODE, MOVE, DONE} state_t;

  state_t      state, state_next;
  logic [11:0] value_lat;
  logic [2:0]  sel;
  logic [15:0] div;
  logic [9:0]  pos [6];
  logic        dir_q [6];

  logic [2:0]  motor_idx;
  logic        cmd_valid;
  logic        accept;
  logic [9:0]  pos_in;
  logic [9:0]  pos_sel;
  logic        dir_sel;
  logic [9:0]  target;
  logic        last_tick;
  logic [9:0]  pos_step;

  // Input decode, and views of the motor being addressed now (pos_in) or
  // by the command in flight (pos_sel/dir_sel).
  always_comb begin
    motor_idx = 3'd0;
    pos_in    = 10'd0;
    pos_sel   = 10'd0;
    dir_sel   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (Motor[i]) motor_idx = 3'(i);
    end
    for (int i = 0; i < 6; i++) begin
      if (motor_idx == 3'(i)) pos_in = pos[i];
      if (sel == 3'(i)) begin
        pos_sel = pos[i];
        dir_sel = dir_q[i];
      end
    end
  end

  assign cmd_valid = $onehot(Motor) && (Value[11:8] <= 4'd9) &&
                     (Value[7:4] <= 4'd9) && (Value[3:0] <= 4'd9);
  assign accept    = (state == IDLE) && Start && cmd_valid;
  assign target    = 10'(value_lat[11:8]) * 10'd100 +
                     10'(value_lat[7:4]) * 10'd10 + 10'(value_lat[3:0]);
  assign last_tick = (state == MOVE) && (div == 16'(STEP_DIV - 1));
  assign pos_step  = dir_sel ? pos_sel + 10'd1 : pos_sel - 10'd1;

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept) state_next = DECODE;
      DECODE: state_next = (target == pos_sel) ? DONE : MOVE;
      MOVE:   if (last_tick && pos_step == target) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == DECODE) || (state == MOVE);
    Done = (state == DONE);
    Step = 6'd0;
    if (state == MOVE && div < 16'(PULSE_W)) Step = 6'd1 << sel;
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      value_lat <= 12'd0;
      sel       <= 3'd0;
      div       <= 16'd0;
      CurPos    <= 10'd0;
      Err       <= 1'b0;
    end else begin
      Err <= (state == IDLE) && Start && !cmd_valid;
      if (accept) begin
        value_lat <= Value;
        sel       <= motor_idx;
        CurPos    <= pos_in;
      end
      if (state == DECODE) div <= 16'd0;
      else if (state == MOVE) div <= last_tick ? 16'd0 : div + 16'd1;
      if (last_tick) CurPos <= pos_step;
    end
  end

  // Per-motor position and direction state; only the selected motor ever changes.
  for (genvar gi = 0; gi < 6; gi++) begin : g_axis
    always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
        pos[gi]   <= 10'd0;
        dir_q[gi] <= 1'b0;
      end else if (sel == 3'(gi)) begin
        if (state == DECODE && target != pos_sel) dir_q[gi] <= (target > pos_sel);
        if (last_tick) pos[gi] <= pos_step;
      end
    end
    assign Dir[gi] = dir_q[gi];
  end

endmodule
